if_fetch_unit: RTL and testbench

Instruction fetch unit for the RV32I core: the consumer of the program counter. Takes the current PC, issues word-aligned read requests to instruction memory over a request/grant/rvalid handshake, and buffers returned instructions with their PC in a 2-entry queue toward decode. It tells the PC register when to advance (`PCStall`) and discards in-flight fetches when the PC is redirected by a branch or jump.

---
 rtl/if_pkg.sv | 24 ++
 rtl/if_inst_buf.sv | 55 +++++
 rtl/if_fetch_unit.sv | 114 +++++++++++
 tb/tb_if_fetch_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the instruction fetch unit
//
// Purpose : FSM state encoding, buffer entry layout and fetch constants.
// Ports   : none (package).
package if_pkg;

  localparam int          BUF_DEPTH = 2;
  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INST  = 32'h00000013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } if_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            err;
  } buf_entry_t;

endpackage

// File: rtl/if_inst_buf.sv
// rtl/if_inst_buf.sv - 2-entry instruction buffer between fetch and decode
//
// Purpose : FIFO of {pc, inst, err}; flush beats push, push and pop may share a cycle.
// Ports   : Clk, Rst          clock, async active-high reset
//           push, push_entry  enqueue request and data
//           pop               dequeue request (ignored when empty)
//           flush             drop every entry this cycle
//           head              entry at the head of the queue
//           count             number of buffered entries (0..2)
module if_inst_buf
  import if_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic       push,
  input  buf_entry_t push_entry,
  input  logic       pop,
  input  logic       flush,
  output buf_entry_t head,
  output logic [1:0] count
);

  buf_entry_t mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic       do_pop;
  logic       do_push;

  assign do_pop  = pop && (count != 2'd0);
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - RV32I instruction fetch unit
//
// Purpose : issues word-aligned instruction fetches for the current PC, tags returned
//           words with their PC and queues them toward decode; drops in-flight data
//           when the PC is redirected.
// Ports   : Clk, Rst                      clock, async active-high reset
//           PC, Redirect, PCStall         PC register interface
//           ImemReq, ImemAddr, ImemGnt    fetch request channel
//           ImemRvalid, ImemRdata         fetch response channel
//           InstValid, Inst, InstPC,
//           InstErr, InstReady            decode interface (head of buffer)
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int BUF_DEPTH = if_pkg::BUF_DEPTH,
  parameter int ADDR_W    = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] PC,
  input  logic              Redirect,
  output logic              PCStall,
  output logic              ImemReq,
  output logic [ADDR_W-1:0] ImemAddr,
  input  logic              ImemGnt,
  input  logic              ImemRvalid,
  input  logic [31:0]       ImemRdata,
  output logic              InstValid,
  output logic [31:0]       Inst,
  output logic [ADDR_W-1:0] InstPC,
  output logic              InstErr,
  input  logic              InstReady
);

  if_state_t         state;
  if_state_t         state_next;
  logic [ADDR_W-1:0] tag;
  logic [1:0]        count;
  logic              room;
  logic              misaligned;
  logic              fetch_fire;
  logic              mis_enq;
  logic              push;
  buf_entry_t        push_entry;
  buf_entry_t        head;

  assign ImemAddr   = {PC[ADDR_W-1:2], 2'b00};
  assign misaligned = (PC[1:0] != 2'b00);
  assign room       = (int'(count) < BUF_DEPTH);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
      tag   <= '0;
    end else begin
      state <= state_next;
      if (fetch_fire) tag <= PC;
    end
  end

  always_comb begin
    state_next = state;
    ImemReq    = 1'b0;
    mis_enq    = 1'b0;
    push       = 1'b0;
    push_entry = '0;

    case (state)
      IDLE: state_next = REQ;
      REQ: begin
        // A misaligned PC never reaches memory; it becomes an error NOP instead.
        ImemReq = !Redirect && room && !misaligned;
        mis_enq = !Redirect && room && misaligned;
        if (mis_enq) begin
          push       = 1'b1;
          push_entry = '{pc: PC, inst: NOP_INST, err: 1'b1};
        end
        if (ImemReq && ImemGnt) state_next = WAIT;
      end
      WAIT: begin
        if (ImemRvalid) begin
          // Data returning alongside a redirect belongs to the old path.
          push       = !Redirect;
          push_entry = '{pc: tag, inst: ImemRdata, err: 1'b0};
          state_next = REQ;
        end else if (Redirect) begin
          state_next = DROP;
        end
      end
      DROP: if (ImemRvalid) state_next = REQ;
      default: state_next = IDLE;
    endcase
  end

  assign fetch_fire = ImemReq && ImemGnt;
  assign PCStall    = !(fetch_fire || Redirect || mis_enq);

  if_inst_buf u_buf (
    .Clk        (Clk),
    .Rst        (Rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (InstReady),
    .flush      (Redirect),
    .head       (head),
    .count      (count)
  );

  assign InstValid = (count != 2'd0);
  assign Inst      = head.inst;
  assign InstPC    = head.pc;
  assign InstErr   = head.err;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [31:0] PC = '0;
  logic        Redirect = 1'b0;
  logic        PCStall;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemGnt = 1'b0;
  logic        ImemRvalid = 1'b0;
  logic [31:0] ImemRdata = '0;
  logic        InstValid;
  logic [31:0] Inst;
  logic [31:0] InstPC;
  logic        InstErr;
  logic        InstReady = 1'b0;

  int checks = 0;
  int errors = 0;

  if_fetch_unit #(.BUF_DEPTH(2), .ADDR_W(32)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .PC         (PC),
    .Redirect   (Redirect),
    .PCStall    (PCStall),
    .ImemReq    (ImemReq),
    .ImemAddr   (ImemAddr),
    .ImemGnt    (ImemGnt),
    .ImemRvalid (ImemRvalid),
    .ImemRdata  (ImemRdata),
    .InstValid  (InstValid),
    .Inst       (Inst),
    .InstPC     (InstPC),
    .InstErr    (InstErr),
    .InstReady  (InstReady)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(negedge Clk);
  endtask

  // Leaves the DUT in REQ, just after a falling edge, with all inputs idle.
  task automatic do_reset();
    Rst = 1'b1; Redirect = 1'b0; ImemGnt = 1'b0; ImemRvalid = 1'b0;
    ImemRdata = '0; InstReady = 1'b0;
    tick(); tick();
    Rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    Rst = 1'b1; PC = 32'h13; ImemGnt = 1'b1;
    tick(); tick(); #1;
    checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", ImemReq); end
    checks++; if (PCStall !== 1'b1) begin errors++; $display("FAIL rst_stall got %b exp 1", PCStall); end
    checks++; if (ImemAddr !== 32'h10) begin errors++; $display("FAIL rst_addr got %h exp 00000010", ImemAddr); end
    checks++; if (InstValid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", InstValid); end
    checks++; if (Inst !== 32'h0) begin errors++; $display("FAIL rst_inst got %h exp 0", Inst); end
    checks++; if (InstPC !== 32'h0) begin errors++; $display("FAIL rst_instpc got %h exp 0", InstPC); end
    checks++; if (InstErr !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", InstErr); end
    PC = 32'h0; Rst = 1'b0; #1;
    checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL idle_req got %b exp 0", ImemReq); end
    ImemGnt = 1'b0;
  endtask

  task automatic test_basic_fetch();
    do_reset();
    PC = 32'h0; ImemGnt = 1'b1; #1;
    checks++; if (ImemReq !== 1'b1) begin errors++; $display("FAIL basic_req got %b exp 1", ImemReq); end
    checks++; if (PCStall !== 1'b0) begin errors++; $display("FAIL basic_stall_grant got %b exp 0", PCStall); end
    checks++; if (ImemAddr !== 32'h0) begin errors++; $display("FAIL basic_addr got %h exp 0", ImemAddr); end
    tick(); ImemGnt = 1'b0; ImemRvalid = 1'b1; ImemRdata = 32'h00500093; PC = 32'h4; #1;
    checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL basic_wait_req got %b exp 0", ImemReq); end
    checks++; if (PCStall !== 1'b1) begin errors++; $display("FAIL basic_wait_stall got %b exp 1", PCStall); end
    checks++; if (InstValid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b exp 0", InstValid); end
    tick(); ImemRvalid = 1'b0; #1;
    checks++; if (InstValid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", InstValid); end
    checks++; if (Inst !== 32'h00500093) begin errors++; $display("FAIL basic_inst got %h exp 00500093", Inst); end
    checks++; if (InstPC !== 32'h0) begin errors++; $display("FAIL basic_instpc got %h exp 0", InstPC); end
    checks++; if (InstErr !== 1'b0) begin errors++; $display("FAIL basic_err got %b exp 0", InstErr); end
  endtask

  task automatic fill_two(input logic [31:0] base);
    PC = base; ImemGnt = 1'b1;
    tick(); ImemGnt = 1'b0; ImemRvalid = 1'b1; ImemRdata = 32'hA0A0_0001; PC = base + 32'h4;
    tick(); ImemRvalid = 1'b0; ImemGnt = 1'b1;
    tick(); ImemGnt = 1'b0; ImemRvalid = 1'b1; ImemRdata = 32'hB0B0_0002; PC = base + 32'h8;
    tick(); ImemRvalid = 1'b0;
  endtask

  task automatic test_buffer_full();
    do_reset();
    fill_two(32'h0);
    ImemGnt = 1'b1; #1;
    checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL full_req got %b exp 0", ImemReq); end
    checks++; if (PCStall !== 1'b1) begin errors++; $display("FAIL full_stall got %b exp 1", PCStall); end
    checks++; if (Inst !== 32'hA0A0_0001) begin errors++; $display("FAIL full_head_inst got %h exp a0a00001", Inst); end
    checks++; if (InstPC !== 32'h0) begin errors++; $display("FAIL full_head_pc got %h exp 0", InstPC); end
    InstReady = 1'b1;
    tick(); InstReady = 1'b0; #1;
    checks++; if (ImemReq !== 1'b1) begin errors++; $display("FAIL pop_req got %b exp 1", ImemReq); end
    checks++; if (Inst !== 32'hB0B0_0002) begin errors++; $display("FAIL pop_head_inst got %h exp b0b00002", Inst); end
    checks++; if (InstPC !== 32'h4) begin errors++; $display("FAIL pop_head_pc got %h exp 4", InstPC); end
    ImemGnt = 1'b0;
  endtask

  task automatic test_redirect_wait();
    do_reset();
    PC = 32'h0; ImemGnt = 1'b1;
    tick(); ImemGnt = 1'b0; Redirect = 1'b1; PC = 32'h100; #1;
    checks++; if (PCStall !== 1'b0) begin errors++; $display("FAIL redir_stall got %b exp 0", PCStall); end
    tick(); Redirect = 1'b0; ImemRvalid = 1'b1; ImemRdata = 32'hDEADBEEF; ImemGnt = 1'b1; #1;
    checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL drop_req got %b exp 0", ImemReq); end
    checks++; if (PCStall !== 1'b1) begin errors++; $display("FAIL drop_stall got %b exp 1", PCStall); end
    tick(); ImemRvalid = 1'b0; #1;
    checks++; if (InstValid !== 1'b0) begin errors++; $display("FAIL drop_valid got %b exp 0", InstValid); end
    checks++; if (ImemReq !== 1'b1) begin errors++; $display("FAIL refetch_req got %b exp 1", ImemReq); end
    checks++; if (ImemAddr !== 32'h100) begin errors++; $display("FAIL refetch_addr got %h exp 00000100", ImemAddr); end
    tick(); ImemGnt = 1'b0; ImemRvalid = 1'b1; ImemRdata = 32'h1111_1111; PC = 32'h104;
    tick(); ImemRvalid = 1'b0; #1;
    checks++; if (InstPC !== 32'h100) begin errors++; $display("FAIL refetch_instpc got %h exp 00000100", InstPC); end
    checks++; if (Inst !== 32'h1111_1111) begin errors++; $display("FAIL refetch_inst got %h exp 11111111", Inst); end
  endtask

  task automatic test_redirect_flush();
    do_reset();
    fill_two(32'h0);
    Redirect = 1'b1; PC = 32'h200; #1;
    checks++; if (PCStall !== 1'b0) begin errors++; $display("FAIL flush2_stall got %b exp 0", PCStall); end
    checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL flush2_req got %b exp 0", ImemReq); end
    tick(); Redirect = 1'b0; #1;
    checks++; if (InstValid !== 1'b0) begin errors++; $display("FAIL flush2_valid got %b exp 0", InstValid); end
    ImemGnt = 1'b1;
    tick(); ImemGnt = 1'b0; ImemRvalid = 1'b1; ImemRdata = 32'h33; PC = 32'h204;
    tick(); ImemRvalid = 1'b0; ImemGnt = 1'b1;
    tick(); ImemGnt = 1'b0; ImemRvalid = 1'b1; ImemRdata = 32'h44; Redirect = 1'b1; PC = 32'h300; #1;
    checks++; if (PCStall !== 1'b0) begin errors++; $display("FAIL rvredir_stall got %b exp 0", PCStall); end
    tick(); ImemRvalid = 1'b0; Redirect = 1'b0; #1;
    checks++; if (InstValid !== 1'b0) begin errors++; $display("FAIL rvredir_valid got %b exp 0", InstValid); end
    checks++; if (ImemReq !== 1'b1) begin errors++; $display("FAIL rvredir_req got %b exp 1", ImemReq); end
    checks++; if (ImemAddr !== 32'h300) begin errors++; $display("FAIL rvredir_addr got %h exp 00000300", ImemAddr); end
  endtask

  task automatic test_misaligned();
    do_reset();
    PC = 32'h102; ImemGnt = 1'b1; #1;
    checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL mis_req got %b exp 0", ImemReq); end
    checks++; if (PCStall !== 1'b0) begin errors++; $display("FAIL mis_stall got %b exp 0", PCStall); end
    checks++; if (ImemAddr !== 32'h100) begin errors++; $display("FAIL mis_addr got %h exp 00000100", ImemAddr); end
    tick(); PC = 32'h104; ImemGnt = 1'b0; #1;
    checks++; if (InstValid !== 1'b1) begin errors++; $display("FAIL mis_valid got %b exp 1", InstValid); end
    checks++; if (Inst !== 32'h00000013) begin errors++; $display("FAIL mis_inst got %h exp 00000013", Inst); end
    checks++; if (InstErr !== 1'b1) begin errors++; $display("FAIL mis_err got %b exp 1", InstErr); end
    checks++; if (InstPC !== 32'h102) begin errors++; $display("FAIL mis_instpc got %h exp 00000102", InstPC); end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    PC = 32'h40; ImemGnt = 1'b1;
    tick(); ImemGnt = 1'b0; ImemRvalid = 1'b1; ImemRdata = 32'h55; PC = 32'h44;
    tick(); ImemRvalid = 1'b0; ImemGnt = 1'b1;
    tick(); ImemGnt = 1'b0; PC = 32'h80; Rst = 1'b1; #1;
    checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL midrst_req got %b exp 0", ImemReq); end
    checks++; if (PCStall !== 1'b1) begin errors++; $display("FAIL midrst_stall got %b exp 1", PCStall); end
    checks++; if (InstValid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", InstValid); end
    checks++; if (Inst !== 32'h0) begin errors++; $display("FAIL midrst_inst got %h exp 0", Inst); end
    checks++; if (InstPC !== 32'h0) begin errors++; $display("FAIL midrst_instpc got %h exp 0", InstPC); end
    tick(); Rst = 1'b0; ImemRvalid = 1'b1; ImemRdata = 32'hBAD;
    tick(); #1;
    tick(); ImemRvalid = 1'b0; ImemGnt = 1'b1; #1;
    checks++; if (InstValid !== 1'b0) begin errors++; $display("FAIL stray_valid got %b exp 0", InstValid); end
    checks++; if (ImemReq !== 1'b1) begin errors++; $display("FAIL restart_req got %b exp 1", ImemReq); end
    checks++; if (ImemAddr !== 32'h80) begin errors++; $display("FAIL restart_addr got %h exp 00000080", ImemAddr); end
    tick(); ImemGnt = 1'b0; ImemRvalid = 1'b1; ImemRdata = 32'h66; PC = 32'h84;
    tick(); ImemRvalid = 1'b0; #1;
    checks++; if (InstPC !== 32'h80) begin errors++; $display("FAIL restart_instpc got %h exp 00000080", InstPC); end
    checks++; if (Inst !== 32'h66) begin errors++; $display("FAIL restart_inst got %h exp 00000066", Inst); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_buffer_full();
    test_redirect_wait();
    test_redirect_flush();
    test_misaligned();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
